// File: rtl/inst_mem_responder_if.sv
// Fetch-side and RAM-side signal bundle for the instruction memory responder.
// The master modport is the fetch stage plus RAM model side; the slave modport is the responder.
interface inst_mem_responder_if;
    logic        rdy;
    logic        has_misbranch;
    logic        in_fetch_ask;
    logic [31:0] in_fetch_addr;
    logic [31:0] out_fetch_inst;
    logic        out_fetch_ready;
    logic        out_busy;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport master (
        output rdy, has_misbranch, in_fetch_ask, in_fetch_addr, mem_din,
        input  out_fetch_inst, out_fetch_ready, out_busy, mem_a, mem_wr
    );

    modport slave (
        input  rdy, has_misbranch, in_fetch_ask, in_fetch_addr, mem_din,
        output out_fetch_inst, out_fetch_ready, out_busy, mem_a, mem_wr
    );
endinterface

// File: rtl/inst_mem_responder.sv
// Instruction fetch responder: assembles a little-endian word from four byte reads of an 8-bit RAM.
// Optional direct-mapped one-word-line I-cache enabled by defining ICACHE_EN.
module inst_mem_responder #(
    parameter int unsigned ICACHE_LINES = 64,
    parameter int unsigned ICACHE_IDX_W = 6
) (
    input logic                 clk,
    input logic                 rst,
    inst_mem_responder_if.slave bus
);
    if (ICACHE_LINES != (32'd1 << ICACHE_IDX_W)) begin : g_bad_cfg
        $error("ICACHE_LINES must equal 2**ICACHE_IDX_W");
    end

    typedef enum logic {IDLE, READ} state_t;

    state_t      state, state_d;
    logic [1:0]  cnt, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [31:0] inst_q, inst_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        fill_c;
    logic        hit_c;
    logic [31:0] hit_line_c;

`ifdef ICACHE_EN
    localparam int unsigned TAG_W = 32 - ICACHE_IDX_W - 2;

    logic [31:0]             line_mem [ICACHE_LINES];
    logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] valid_q;
    logic [ICACHE_IDX_W-1:0] look_idx_c;
    logic [ICACHE_IDX_W-1:0] fill_idx_c;

    assign look_idx_c = bus.in_fetch_addr[ICACHE_IDX_W+1:2];
    assign fill_idx_c = addr_q[ICACHE_IDX_W+1:2];
    assign hit_c      = valid_q[look_idx_c] &&
                        (tag_mem[look_idx_c] == bus.in_fetch_addr[31:ICACHE_IDX_W+2]);
    assign hit_line_c = line_mem[look_idx_c];

    // Valid bits are the only cache state cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_c) begin
            valid_q[fill_idx_c] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_c) begin
            line_mem[fill_idx_c] <= inst_d;
            tag_mem[fill_idx_c]  <= addr_q[31:ICACHE_IDX_W+2];
        end
    end
`else
    assign hit_c      = 1'b0;
    assign hit_line_c = 32'd0;
`endif

    // Next-state: misbranch beats rdy-hold, which beats normal fetch sequencing.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        mem_a_d = mem_a_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        inst_d  = inst_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        fill_c  = 1'b0;

        if (bus.has_misbranch) begin
            state_d = IDLE;
            ready_d = 1'b0;
            busy_d  = 1'b0;
        end else if (bus.rdy) begin
            ready_d = 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.in_fetch_ask) begin
                        if (hit_c) begin
                            inst_d  = hit_line_c;
                            ready_d = 1'b1;
                        end else begin
                            addr_d  = bus.in_fetch_addr;
                            mem_a_d = bus.in_fetch_addr;
                            cnt_d   = 2'd0;
                            busy_d  = 1'b1;
                            state_d = READ;
                        end
                    end
                end
                READ: begin
                    unique case (cnt)
                        2'd0: b0_d = bus.mem_din;
                        2'd1: b1_d = bus.mem_din;
                        2'd2: b2_d = bus.mem_din;
                        default: ;
                    endcase
                    if (cnt != 2'd3) begin
                        mem_a_d = addr_q + 32'(cnt) + 32'd1;
                        cnt_d   = cnt + 2'd1;
                    end else begin
                        inst_d  = {bus.mem_din, b2_q, b1_q, b0_q};
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                        fill_c  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            addr_q  <= 32'd0;
            mem_a_q <= 32'd0;
            b0_q    <= 8'd0;
            b1_q    <= 8'd0;
            b2_q    <= 8'd0;
            inst_q  <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            mem_a_q <= mem_a_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            inst_q  <= inst_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.mem_a           = mem_a_q;
    assign bus.mem_wr          = 1'b0;
    assign bus.out_fetch_inst  = inst_q;
    assign bus.out_fetch_ready = ready_q;
    assign bus.out_busy        = busy_q;
endmodule

// File: tb/tb_inst_mem_responder.sv
// Randomized self-checking bench for inst_mem_responder against a transaction-level model.
// Also models the I-cache when compiled with ICACHE_EN.
module tb_inst_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_mem_responder_if bus ();

    inst_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // RAM contents: fixed test words, pseudo-random bytes elsewhere.
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h00;
            32'h103: return 8'h00;
            32'h104: return 8'h93;
            32'h105: return 8'h00;
            32'h106: return 8'h10;
            32'h107: return 8'h00;
            32'h200: return 8'h93;
            32'h201: return 8'h00;
            32'h202: return 8'hA0;
            32'h203: return 8'h00;
            default: return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    assign bus.mem_din = ram_rd(bus.mem_a);

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {ram_rd(a + 32'd3), ram_rd(a + 32'd2), ram_rd(a + 32'd1), ram_rd(a)};
    endfunction

`ifdef ICACHE_EN
    logic [31:0] cache_addr [int];

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'((a >> 2) % 32'd64);
        return cache_addr.exists(idx) && (cache_addr[idx] == a);
    endfunction
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch from accept to pulse (or squash); returns in the pulse cycle.
    task automatic do_fetch(input logic [31:0] a, input int squash_at, input int stall_at,
                            input int stall_len, input bit rnd, input bit hold_pulse);
        logic [31:0] prev_mem_a;
        bit hit;
        bit squash;
        int n;
        int stalled;
        int guard;
        prev_mem_a = bus.mem_a;
        hit = 1'b0;
`ifdef ICACHE_EN
        hit = model_hit(a);
`endif
        bus.in_fetch_ask  = 1'b1;
        bus.in_fetch_addr = a;
        bus.rdy           = 1'b1;
        bus.has_misbranch = 1'b0;
        tick();
        bus.in_fetch_ask  = 1'b0;
        bus.in_fetch_addr = $urandom;
        if (hit) begin
            check_eq("hit_ready", 32'(bus.out_fetch_ready), 32'd1);
            check_eq("hit_inst", bus.out_fetch_inst, word_of(a));
            check_eq("hit_mem_a", bus.mem_a, prev_mem_a);
            check_eq("hit_busy", 32'(bus.out_busy), 32'd0);
            return;
        end
        check_eq("acc_busy", 32'(bus.out_busy), 32'd1);
        check_eq("acc_ready", 32'(bus.out_fetch_ready), 32'd0);
        check_eq("acc_mem_a", bus.mem_a, a);
        n = 0;
        stalled = 0;
        guard = 0;
        while (n < 4 && guard < 200) begin
            guard++;
            if (rnd) bus.rdy = ($urandom_range(0, 3) != 0);
            else if (stall_at != 0 && n == stall_at && stalled < stall_len) begin
                bus.rdy = 1'b0;
                stalled++;
            end else bus.rdy = 1'b1;
            squash = (squash_at != 0 && n == squash_at - 1);
            bus.has_misbranch = squash;
            if (squash) begin
                bus.in_fetch_ask  = 1'b1;
                bus.in_fetch_addr = $urandom & 32'hFFFF_FFFC;
            end
            tick();
            bus.has_misbranch = 1'b0;
            bus.in_fetch_ask  = 1'b0;
            if (squash) begin
                check_eq("sq_ready", 32'(bus.out_fetch_ready), 32'd0);
                check_eq("sq_busy", 32'(bus.out_busy), 32'd0);
                check_eq("sq_mem_a", bus.mem_a, a + 32'(n));
                bus.rdy = 1'b1;
                return;
            end
            if (bus.rdy) n++;
            check_eq("rd_ready", 32'(bus.out_fetch_ready), 32'(n == 4));
            check_eq("rd_busy", 32'(bus.out_busy), 32'(n < 4));
            check_eq("rd_mem_a", bus.mem_a, a + 32'((n < 4) ? n : 3));
        end
        if (guard >= 200) begin
            check_eq("timeout", 32'(n), 32'd4);
            bus.rdy = 1'b1;
            return;
        end
        check_eq("inst", bus.out_fetch_inst, word_of(a));
`ifdef ICACHE_EN
        cache_addr[int'((a >> 2) % 32'd64)] = a;
`endif
        if (hold_pulse) begin
            bus.rdy = 1'b0;
            repeat (2) begin
                tick();
                check_eq("hold_ready", 32'(bus.out_fetch_ready), 32'd1);
                check_eq("hold_inst", bus.out_fetch_inst, word_of(a));
            end
        end
        bus.rdy = 1'b1;
    endtask

    initial begin
        logic [31:0] ra;
        rst = 1'b0;
        bus.rdy = 1'b1;
        bus.has_misbranch = 1'b0;
        bus.in_fetch_ask = 1'b0;
        bus.in_fetch_addr = 32'd0;
        #12;
        check_eq("rst_mem_a", bus.mem_a, 32'd0);
        check_eq("rst_inst", bus.out_fetch_inst, 32'd0);
        check_eq("rst_ready", 32'(bus.out_fetch_ready), 32'd0);
        check_eq("rst_busy", 32'(bus.out_busy), 32'd0);
        check_eq("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        rst = 1'b1;
        tick();

        do_fetch(32'h100, 0, 0, 0, 1'b0, 1'b0);
        check_eq("t1_word", bus.out_fetch_inst, 32'h0000_0513);
        do_fetch(32'h100, 2, 0, 0, 1'b0, 1'b0);
        tick();
        check_eq("t2_no_pulse", 32'(bus.out_fetch_ready), 32'd0);
        do_fetch(32'h200, 0, 0, 0, 1'b0, 1'b0);
        check_eq("t2_word", bus.out_fetch_inst, 32'h00A0_0093);
        tick();
        do_fetch(32'h104, 0, 2, 3, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a read.
        bus.in_fetch_ask = 1'b1;
        bus.in_fetch_addr = 32'h300;
        tick();
        bus.in_fetch_ask = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        check_eq("ar_mem_a", bus.mem_a, 32'd0);
        check_eq("ar_inst", bus.out_fetch_inst, 32'd0);
        check_eq("ar_busy", 32'(bus.out_busy), 32'd0);
        check_eq("ar_ready", 32'(bus.out_fetch_ready), 32'd0);
`ifdef ICACHE_EN
        cache_addr.delete();
`endif
        #4 rst = 1'b1;
        tick();
        do_fetch(32'h100, 0, 0, 0, 1'b0, 1'b0);
        do_fetch(32'h104, 0, 0, 0, 1'b0, 1'b0);
        check_eq("t5_word", bus.out_fetch_inst, 32'h0010_0093);
`ifndef ICACHE_EN
        do_fetch(32'hFFFF_FFFE, 0, 0, 0, 1'b0, 1'b0);
`endif
`ifdef ICACHE_EN
        do_fetch(32'h100, 0, 0, 0, 1'b0, 1'b0);
        do_fetch(32'h100, 0, 0, 0, 1'b0, 1'b0);
        do_fetch(32'h200, 0, 0, 0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 32'h100;
                1: ra = 32'h104;
                2: ra = 32'h200;
                3: ra = 32'h1000 + 32'($urandom_range(0, 3) * 256);
                default: ra = $urandom;
            endcase
`ifdef ICACHE_EN
            ra = ra & 32'hFFFF_FFFC;
`endif
            do_fetch(ra, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0,
                     0, 0, 1'b1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
